alu_mbyte_seq: RTL and testbench

- Multi-byte arithmetic sequencer for the uPx1 ALU.
- Runs ADD/ADC/SUB/SBB on NBYTES-wide operands by driving the shared 8-bit carry-lookahead adder (add8) one byte per clock, LSB first, and chaining carry between bytes.
- Sits between the instruction decoder/register file and the adder. Captures each byte result into a shadow register and publishes the full result plus C/Z/V/N flags on completion.

---
 rtl/alu_mbyte_seq.sv | 128 ++++++++++++
 tb/tb_alu_mbyte_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_mbyte_seq.sv
// alu_mbyte_seq: multi-byte ADD/ADC/SUB/SBB sequencer driving an external 8-bit add8 one byte per clock, LSB first
// Optional saturation on signed overflow is enabled by defining ALU_MBYTE_SEQ_SAT_EN.
module alu_mbyte_seq #(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [8*NBYTES-1:0] a_in,
  input  logic [8*NBYTES-1:0] b_in,
  input  logic                c_flag_in,
  input  logic                abort,
  output logic                alu_en,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic                alu_cin,
  input  logic [7:0]          alu_s,
  input  logic                alu_cout,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                c_flag,
  output logic                z_flag,
  output logic                v_flag,
  output logic                n_flag
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] a_r, b_r, shadow, sh_nxt, res_nxt;
  logic [IW-1:0] idx, nidx;
  logic zacc, z_nxt, z_fin, v_raw, last;
  always_comb begin
    last = idx == IW'(NBYTES - 1);
    nidx = idx + 1'b1;
    sh_nxt = shadow;
    sh_nxt[8*idx +: 8] = alu_s;
    z_nxt = zacc & (alu_s == 8'h00);
    // on the last byte the adder inputs are the operand MSBs, B already inverted for subtraction
    v_raw = (alu_a[7] == alu_b[7]) && (alu_s[7] != alu_a[7]);
`ifdef ALU_MBYTE_SEQ_SAT_EN
    res_nxt = !v_raw ? sh_nxt : alu_a[7] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    z_fin = z_nxt & ~v_raw;
`else
    res_nxt = sh_nxt;
    z_fin = z_nxt;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      shadow <= '0;
      idx <= '0;
      zacc <= 1'b0;
      alu_en <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_cin <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      v_flag <= 1'b0;
      n_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            a_r <= a_in;
            b_r <= op[1] ? ~b_in : b_in;
            idx <= '0;
            zacc <= 1'b1;
            busy <= 1'b1;
            alu_en <= 1'b1;
            alu_a <= a_in[7:0];
            alu_b <= op[1] ? ~b_in[7:0] : b_in[7:0];
            alu_cin <= op[0] ? c_flag_in : op[1];
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy <= 1'b0;
            alu_en <= 1'b0;
            alu_a <= '0;
            alu_b <= '0;
            alu_cin <= 1'b0;
          end else begin
            shadow <= sh_nxt;
            zacc <= z_nxt;
            idx <= nidx;
            if (last) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
              alu_en <= 1'b0;
              alu_a <= '0;
              alu_b <= '0;
              alu_cin <= 1'b0;
              result <= res_nxt;
              c_flag <= alu_cout;
              z_flag <= z_fin;
              v_flag <= v_raw;
              n_flag <= res_nxt[W-1];
            end else begin
              alu_a <= a_r[8*nidx +: 8];
              alu_b <= b_r[8*nidx +: 8];
              alu_cin <= alu_cout;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          idx <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mbyte_seq.sv
// tb_alu_mbyte_seq: directed self-checking bench for alu_mbyte_seq (NBYTES=2) with a behavioural add8
module tb_alu_mbyte_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, c_flag_in = 1'b0;
  logic [1:0] op = 2'b00;
  logic [15:0] a_in = '0, b_in = '0, result;
  logic alu_en, alu_cin, alu_cout, busy, done, c_flag, z_flag, v_flag, n_flag;
  logic [7:0] alu_a, alu_b, alu_s;
  int cmp = 0, bad = 0;
  typedef struct {
    logic [1:0] op; logic [15:0] a, b; logic cf;
    logic [15:0] res; logic [3:0] f; logic [7:0] b0, b1; logic ci0, ci1;
  } vec_t;
  vec_t vt[7];
  always #5 clk = ~clk;
  assign {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
  alu_mbyte_seq #(.NBYTES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .c_flag_in(c_flag_in), .abort(abort), .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_s(alu_s), .alu_cout(alu_cout), .busy(busy), .done(done),
    .result(result), .c_flag(c_flag), .z_flag(z_flag), .v_flag(v_flag), .n_flag(n_flag)
  );
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic cf);
    op = o; a_in = a; b_in = b; c_flag_in = cf; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_in = ~a; b_in = ~b; c_flag_in = ~cf;
  endtask
  task automatic test_reset;
    #3;
    cmp++;
    if ({busy, done, alu_en, alu_a, alu_b, alu_cin, result, c_flag, z_flag, v_flag, n_flag} !== '0) begin
      bad++; $display("FAIL reset_state: got busy=%b done=%b en=%b res=%h", busy, done, alu_en, result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_arith;
    vt[0] = '{2'b00, 16'h12FF, 16'h0001, 1'b0, 16'h1300, 4'b0000, 8'h01, 8'h00, 1'b0, 1'b1};
    vt[1] = '{2'b10, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 4'b1000, 8'hFE, 8'hFF, 1'b1, 1'b0};
    vt[2] = '{2'b10, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 4'b0001, 8'hFD, 8'hFF, 1'b1, 1'b0};
    vt[3] = '{2'b01, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b1100, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[4] = '{2'b11, 16'h0005, 16'h0003, 1'b0, 16'h0001, 4'b1000, 8'hFC, 8'hFF, 1'b0, 1'b1};
`ifdef ALU_MBYTE_SEQ_SAT_EN
    vt[5] = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 4'b0010, 8'h01, 8'h00, 1'b0, 1'b1};
    vt[6] = '{2'b10, 16'h8000, 16'h0001, 1'b0, 16'h8000, 4'b1011, 8'hFE, 8'hFF, 1'b1, 1'b0};
`else
    vt[5] = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0011, 8'h01, 8'h00, 1'b0, 1'b1};
    vt[6] = '{2'b10, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b1010, 8'hFE, 8'hFF, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 7; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].cf);
      cmp++;
      if ({busy, done, alu_en, alu_a, alu_b, alu_cin} !== {3'b101, vt[i].a[7:0], vt[i].b0, vt[i].ci0}) begin
        bad++; $display("FAIL arith%0d_byte0: got a=%h b=%h cin=%b en=%b, want a=%h b=%h cin=%b",
          i, alu_a, alu_b, alu_cin, alu_en, vt[i].a[7:0], vt[i].b0, vt[i].ci0);
      end
      @(posedge clk); #1;
      cmp++;
      if ({busy, done, alu_en, alu_a, alu_b, alu_cin} !== {3'b101, vt[i].a[15:8], vt[i].b1, vt[i].ci1}) begin
        bad++; $display("FAIL arith%0d_byte1: got a=%h b=%h cin=%b done=%b, want a=%h b=%h cin=%b",
          i, alu_a, alu_b, alu_cin, done, vt[i].a[15:8], vt[i].b1, vt[i].ci1);
      end
      @(posedge clk); #1;
      cmp++;
      if ({busy, done, alu_en, result, c_flag, z_flag, v_flag, n_flag} !== {3'b010, vt[i].res, vt[i].f}) begin
        bad++; $display("FAIL arith%0d_result: got done=%b res=%h czvn=%b%b%b%b, want res=%h czvn=%b",
          i, done, result, c_flag, z_flag, v_flag, n_flag, vt[i].res, vt[i].f);
      end
      @(posedge clk); #1;
      cmp++;
      if ({done, busy, alu_en} !== 3'b000) begin
        bad++; $display("FAIL arith%0d_done_width: got done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
  endtask
  task automatic test_abort;
    logic seen = 1'b0;
    issue(2'b00, 16'h0001, 16'h0001, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    cmp++;
    if ({busy, alu_en, alu_a, alu_b, alu_cin} !== '0) begin
      bad++; $display("FAIL abort_idle: got busy=%b en=%b a=%h, want 0", busy, alu_en, alu_a);
    end
    for (int k = 0; k < 4; k++) begin
      seen |= done;
      @(posedge clk); #1;
    end
    cmp++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL abort_no_done: got done pulse=%b, want 0", seen);
    end
    cmp++;
    if ({result, c_flag, z_flag, v_flag, n_flag} !== {vt[6].res, vt[6].f}) begin
      bad++; $display("FAIL abort_keep: got res=%h czvn=%b%b%b%b, want res=%h czvn=%b",
        result, c_flag, z_flag, v_flag, n_flag, vt[6].res, vt[6].f);
    end
    op = 2'b00; a_in = 16'h0001; b_in = 16'h0001; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    cmp++;
    if ({busy, alu_en} !== 2'b00) begin
      bad++; $display("FAIL start_with_abort: got busy=%b en=%b, want 0 0", busy, alu_en);
    end
  endtask
  task automatic test_start_during_run;
    issue(2'b00, 16'h0010, 16'h0020, 1'b0);
    start = 1'b1; a_in = 16'h5555; b_in = 16'h1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    cmp++;
    if ({done, result, c_flag, z_flag, v_flag, n_flag} !== {1'b1, 16'h0030, 4'b0000}) begin
      bad++; $display("FAIL run_start_ignored: got done=%b res=%h, want done=1 res=0030", done, result);
    end
    @(posedge clk); #1;
    cmp++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL run_start_not_queued: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask
  task automatic test_back_to_back;
    logic [11:0] rec;
    op = 2'b00; a_in = 16'h0001; b_in = 16'h0001; c_flag_in = 1'b0; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      rec[k] = done;
    end
    start = 1'b0;
    cmp++;
    if (rec !== 12'h444) begin
      bad++; $display("FAIL back_to_back: got done pattern=%h, want 444", rec);
    end
    cmp++;
    if (result !== 16'h0002) begin
      bad++; $display("FAIL back_to_back_res: got %h, want 0002", result);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic test_async_reset;
    issue(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if ({busy, done, alu_en, alu_a, alu_b, alu_cin, result, c_flag, z_flag, v_flag, n_flag} !== '0) begin
      bad++; $display("FAIL async_reset: got busy=%b en=%b a=%h res=%h, want all 0", busy, alu_en, alu_a, result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b00, 16'h0102, 16'h0304, 1'b0);
    @(posedge clk); #1;
    cmp++;
    if ({busy, done} !== 2'b10) begin
      bad++; $display("FAIL post_reset_latency: got busy=%b done=%b after 1 edge, want 1 0", busy, done);
    end
    @(posedge clk); #1;
    cmp++;
    if ({done, result, c_flag, z_flag, v_flag, n_flag} !== {1'b1, 16'h0406, 4'b0000}) begin
      bad++; $display("FAIL post_reset_add: got done=%b res=%h, want done=1 res=0406", done, result);
    end
  endtask
  initial begin
    test_reset;
    test_arith;
    test_abort;
    test_start_during_run;
    test_back_to_back;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
